// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the CPE142 EX-stage ALU control and the sequenced
// multiply/divide engine.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRL = 4'b1001;
  localparam logic [3:0] F_ROL = 4'b1010;
  localparam logic [3:0] F_ROR = 4'b1011;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_AND = 3'b010;
  localparam logic [2:0] C_OR  = 3'b011;
  localparam logic [2:0] C_SLL = 3'b100;
  localparam logic [2:0] C_SRL = 3'b101;
  localparam logic [2:0] C_ROL = 3'b110;
  localparam logic [2:0] C_ROR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per clock, WIDTH iterations per operation.
module mul_div_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  // acc = {partial product high, multiplier remaining}; carry goes into the top bit.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : '0)};
    return {sum, p[WIDTH-1:1]};
  endfunction

  // acc = {partial remainder, dividend bits / quotient bits shifting in}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {r[2*WIDTH-1:WIDTH], r[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (sh >= {1'b0, d}) return {diff[WIDTH-1:0], r[WIDTH-2:0], 1'b1};
    else                 return {sh[WIDTH-1:0],   r[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (!start)   state_nxt = S_IDLE;
        else if (!op) state_nxt = S_MUL;
        else          state_nxt = (b == '0) ? S_DONE : S_DIV;
      end
      S_MUL, S_DIV: if (cnt == LAST) state_nxt = S_DONE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      opnd <= '0;
      acc  <= '0;
      dz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt <= '0;
            if (!op) begin
              opnd <= a;
              acc  <= {{WIDTH{1'b0}}, b};
              dz   <= 1'b0;
            end else begin
              opnd <= b;
              // A zero divisor short-circuits: quotient all ones, remainder = dividend.
              acc  <= (b == '0) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a};
              dz   <= (b == '0);
            end
          end
        end
        S_MUL: begin
          acc <= mul_step(acc, opnd);
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          acc <= div_step(acc, opnd);
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == S_MUL) || (state == S_DIV);
  assign done   = (state == S_DONE);
  assign res_hi = acc[2*WIDTH-1:WIDTH];
  assign res_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control: combinational ALUop/funct decode plus a stall
// handshake around the sequenced multiply/divide engine.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [1:0]         ALUop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               illegal,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo,
  output logic               dz
);

  logic is_md;
  logic start;
  logic op_div;

  always_comb begin
    ctrl    = CTRL_W'(C_ADD);
    illegal = 1'b0;
    is_md   = 1'b0;
    case (ALUop)
      ALUOP_MEM: ctrl = CTRL_W'(C_ADD);
      ALUOP_BR:  ctrl = CTRL_W'(C_SUB);
      ALUOP_I:   ctrl = CTRL_W'(C_OR);
      ALUOP_R: begin
        case (funct)
          FUNCT_W'(F_ADD): ctrl = CTRL_W'(C_ADD);
          FUNCT_W'(F_SUB): ctrl = CTRL_W'(C_SUB);
          FUNCT_W'(F_AND): ctrl = CTRL_W'(C_AND);
          FUNCT_W'(F_OR):  ctrl = CTRL_W'(C_OR);
          FUNCT_W'(F_SLL): ctrl = CTRL_W'(C_SLL);
          FUNCT_W'(F_SRL): ctrl = CTRL_W'(C_SRL);
          FUNCT_W'(F_ROL): ctrl = CTRL_W'(C_ROL);
          FUNCT_W'(F_ROR): ctrl = CTRL_W'(C_ROR);
          FUNCT_W'(F_MUL), FUNCT_W'(F_DIV): is_md = 1'b1;
          default: illegal = valid;
        endcase
      end
      default: ;
    endcase
  end

  // The engine accepts only when idle or finishing, so DONE can chain the next op.
  assign op_div = (funct == FUNCT_W'(F_DIV));
  assign start  = valid & is_md & ~busy;
  assign stall  = start | busy;

  mul_div_seq #(
    .WIDTH(WIDTH)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_div),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .dz     (dz)
  );

endmodule
